stopwatch_seq_ctrl: RTL

Controller that sequences the 4-digit BCD counter/display path as a stopwatch. Debounces three push-keys and runs a start/pause/lap/clear state machine. Issues single-cycle increment and clear strobes to an external BCD counter at one of four selectable rates. Time-multiplexes either the live count or a frozen lap value onto the 4-digit common-anode display. Everything runs synchronously in the clk domain; no derived clocks.

---
 rtl/stopwatch_seq_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_seq_ctrl.sv
// Stopwatch sequencer: key debounce, start/pause/lap/clear FSM, tick prescaler and display scan.
// Optional build macro STOPWATCH_AUTOSTOP_EN halts the run at 9999 instead of wrapping.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | stopped, count cleared or never started
// RUN   | prescaler running, live count displayed
// LAP   | prescaler running, frozen lap value displayed
// PAUSE | prescaler held, live count displayed
module stopwatch_seq_ctrl #(
  parameter int DEB_CYC  = 16,
  parameter int TICK_DIV = 16777216,
  parameter int SCAN_DIV = 16384
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        key_start,
  input  logic        key_lap,
  input  logic        key_rate,
  input  logic [15:0] cnt_val,
  output logic        cnt_inc,
  output logic        cnt_zero,
  output logic [3:0]  digit,
  output logic [3:0]  com,
  output logic [1:0]  state,
  output logic [1:0]  rate
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

  localparam logic [DW-1:0] DEB_LD  = DW'(DEB_CYC - 1);
  localparam logic [SW-1:0] SCAN_LD = SW'(SCAN_DIV - 1);

  logic [2:0]    keys;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    armed;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  logic          p_start;
  logic          p_lap;
  logic          p_rate;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [1:0]    rate_q;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_term;
  logic          running;
  logic          tick;
  logic          stop_hit;
  logic          zero_d;
  logic          lap_cap;
  logic          presc_clr;
  logic [15:0]   lap_reg;
  logic [15:0]   disp;
  logic [SW-1:0] scan_tmr;
  logic [1:0]    scan;

  assign keys    = {key_rate, key_lap, key_start};
  assign p_start = press[0];
  assign p_lap   = press[1];
  assign p_rate  = press[2];

  // Timer counts down while the key sits in the opposite level to what the
  // armed flag waits for: low when armed (press), high when disarmed (release).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= '1;
      sync2 <= '1;
      armed <= '1;
      press <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= DEB_LD;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (armed[i] ^ sync2[i]) begin
          if (deb_cnt[i] == '0) begin
            press[i]   <= armed[i];
            armed[i]   <= ~armed[i];
            deb_cnt[i] <= DEB_LD;
          end else begin
            deb_cnt[i] <= deb_cnt[i] - DW'(1);
          end
        end else begin
          deb_cnt[i] <= DEB_LD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rate_q <= 2'd0;
    else if (p_rate) rate_q <= rate_q + 2'd1;
  end

  always_comb begin
    presc_term = PW'(TICK_DIV - 1);
    unique case (rate_q)
      2'd0: presc_term = PW'(TICK_DIV - 1);
      2'd1: presc_term = PW'((TICK_DIV >> 3) - 1);
      2'd2: presc_term = PW'((TICK_DIV >> 6) - 1);
      2'd3: presc_term = PW'((TICK_DIV >> 9) - 1);
    endcase
  end

  assign running = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick    = running && (presc == presc_term);

`ifdef STOPWATCH_AUTOSTOP_EN
  assign stop_hit = tick && (cnt_val == 16'h9999);
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) presc <= '0;
    else if (p_rate || presc_clr || tick) presc <= '0;
    else if (running) presc <= presc + PW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  // FSM: next state; start has priority over lap, autostop over both
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (p_start) state_d = S_RUN;
      S_RUN:   if (p_start) state_d = S_PAUSE; else if (p_lap) state_d = S_LAP;
      S_LAP:   if (p_start) state_d = S_PAUSE; else if (p_lap) state_d = S_RUN;
      S_PAUSE: if (p_start) state_d = S_RUN;   else if (p_lap) state_d = S_IDLE;
    endcase
    if (stop_hit) state_d = S_PAUSE;
  end

  // FSM: transition-derived controls
  always_comb begin
    zero_d    = (state_q == S_PAUSE) && (state_d == S_IDLE);
    lap_cap   = (state_q == S_RUN)   && (state_d == S_LAP);
    presc_clr = (state_q == S_IDLE)  && (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_inc  <= 1'b0;
      cnt_zero <= 1'b0;
      lap_reg  <= 16'h0000;
    end else begin
      cnt_inc  <= tick && !stop_hit;
      cnt_zero <= zero_d;
      if (lap_cap) lap_reg <= cnt_val;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      scan_tmr <= SCAN_LD;
      scan     <= 2'd0;
    end else if (scan_tmr == '0) begin
      scan_tmr <= SCAN_LD;
      scan     <= scan + 2'd1;
    end else begin
      scan_tmr <= scan_tmr - SW'(1);
    end
  end

  assign disp = (state_q == S_LAP) ? lap_reg : cnt_val;

  always_comb begin
    com   = 4'b0111;
    digit = disp[15:12];
    unique case (scan)
      2'd0: begin com = 4'b0111; digit = disp[15:12]; end
      2'd1: begin com = 4'b1011; digit = disp[11:8];  end
      2'd2: begin com = 4'b1101; digit = disp[7:4];   end
      2'd3: begin com = 4'b1110; digit = disp[3:0];   end
    endcase
  end

  assign state = state_q;
  assign rate  = rate_q;

endmodule
